// File: rtl/reg_file_if.sv
// reg_file_if: bus bundle for the reg_file register array.
//   clr            synchronous clear of every entry at the next rising edge
//   we/waddr/wdata write port
//   raddr1/raddr2  read addresses for the two independent read ports
//   rdata1/rdata2  combinational read data
// The master modport drives the request side. The slave modport is the register file.
interface reg_file_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 5
);
  logic             clr;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr1;
  logic [AW-1:0]    raddr2;
  logic [WIDTH-1:0] rdata1;
  logic [WIDTH-1:0] rdata2;

  modport master (
    output clr, we, waddr, wdata, raddr1, raddr2,
    input  rdata1, rdata2
  );

  modport slave (
    input  clr, we, waddr, wdata, raddr1, raddr2,
    output rdata1, rdata2
  );
endinterface

// File: rtl/reg_file.sv
// reg_file: DEPTH x WIDTH register array with one write port and two
// combinational read ports. It has the following options:
//   - ZERO_REG: entry 0 is hardwired to zero.
//   - BYPASS:   a write is forwarded to a matching read port in the same cycle.
//   - clr:      a synchronous clear of every entry.
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous active-low reset, clears every entry
//   bus  reg_file_if slave modport (clr, we, waddr, wdata, raddr1/2, rdata1/2)
// Priority at an edge: rst=0, then clr, then write, then hold.
// Addresses >= DEPTH are dropped on write and read as zero.
module reg_file #(
  parameter  int WIDTH    = 32,
  parameter  int DEPTH    = 32,
  parameter  int ZERO_REG = 1,
  parameter  int BYPASS   = 1,
  localparam int AW       = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  reg_file_if.slave   bus
);

  // One extra bit so that DEPTH itself is representable for the range compare.
  localparam logic [AW:0] DEPTH_W = DEPTH[AW:0];

  logic [WIDTH-1:0] mem [DEPTH];

  logic in_w, in_r1, in_r2;
  logic wr_en;

  assign in_w  = ({1'b0, bus.waddr}  < DEPTH_W);
  assign in_r1 = ({1'b0, bus.raddr1} < DEPTH_W);
  assign in_r2 = ({1'b0, bus.raddr2} < DEPTH_W);

  // A write is accepted only when it targets a real, writable entry.
  // The same condition is used to qualify the bypass path.
  assign wr_en = rst && bus.we && !bus.clr && in_w &&
                 !((ZERO_REG != 0) && (bus.waddr == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (bus.clr) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  always_comb begin
    bus.rdata1 = '0;
    if (in_r1 && !((ZERO_REG != 0) && (bus.raddr1 == '0)))
      bus.rdata1 = mem[bus.raddr1];
    if ((BYPASS != 0) && wr_en && (bus.raddr1 == bus.waddr))
      bus.rdata1 = bus.wdata;
  end

  always_comb begin
    bus.rdata2 = '0;
    if (in_r2 && !((ZERO_REG != 0) && (bus.raddr2 == '0)))
      bus.rdata2 = mem[bus.raddr2];
    if ((BYPASS != 0) && wr_en && (bus.raddr2 == bus.waddr))
      bus.rdata2 = bus.wdata;
  end

endmodule

// File: tb/tb_reg_file.sv
`timescale 1ns/10ps
module tb_reg_file;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reg_file_if #(.WIDTH(32), .AW(5)) ifa ();
  reg_file_if #(.WIDTH(32), .AW(5)) ifb ();
  reg_file_if #(.WIDTH(8),  .AW(5)) ifc ();

  reg_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(1), .BYPASS(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  reg_file #(.WIDTH(32), .DEPTH(32), .ZERO_REG(0), .BYPASS(0)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  reg_file #(.WIDTH(8),  .DEPTH(20), .ZERO_REG(1), .BYPASS(1)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  int total = 0;
  int bad   = 0;

  // Reference model: one plain array per configuration.
  logic [31:0] mdl [3][32];
  int          dp  [3] = '{32, 32, 20};
  int          zr  [3] = '{1, 0, 1};
  int          by  [3] = '{1, 0, 1};
  logic [31:0] msk [3] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_00FF};
  logic [31:0] act1 [3];
  logic [31:0] act2 [3];

  typedef struct {
    bit          we;
    bit          clr;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  r1;
    logic [4:0]  r2;
    logic [31:0] e1;
    logic [31:0] e2;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  function automatic bit wr_ok(input int k, input bit r, input bit we, input bit clr, input logic [4:0] wa);
    return r && we && !clr && (int'(wa) < dp[k]) && !(zr[k] == 1 && wa == 5'd0);
  endfunction

  function automatic logic [31:0] expect_rd(input int k, input bit r, input bit we, input bit clr,
                                            input logic [4:0] wa, input logic [31:0] wd, input logic [4:0] ra);
    if (!r || int'(ra) >= dp[k] || (zr[k] == 1 && ra == 5'd0)) return 32'h0;
    if (by[k] == 1 && wr_ok(k, r, we, clr, wa) && ra == wa) return wd & msk[k];
    return mdl[k][ra];
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 3; k++)
      for (int i = 0; i < 32; i++) mdl[k][i] = 32'h0;
  endtask

  task automatic drive(input bit r, input bit we, input bit clr, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    rst = r;
    ifa.we = we; ifa.clr = clr; ifa.waddr = wa; ifa.wdata = wd;       ifa.raddr1 = r1; ifa.raddr2 = r2;
    ifb.we = we; ifb.clr = clr; ifb.waddr = wa; ifb.wdata = wd;       ifb.raddr1 = r1; ifb.raddr2 = r2;
    ifc.we = we; ifc.clr = clr; ifc.waddr = wa; ifc.wdata = wd[7:0];  ifc.raddr1 = r1; ifc.raddr2 = r2;
  endtask

  task automatic sample();
    act1[0] = ifa.rdata1;           act2[0] = ifa.rdata2;
    act1[1] = ifb.rdata1;           act2[1] = ifb.rdata2;
    act1[2] = {24'h0, ifc.rdata1};  act2[2] = {24'h0, ifc.rdata2};
  endtask

  // One cycle, entered at a falling edge: drive, check reads, clock, update model.
  task automatic step(input bit r, input bit we, input bit clr, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] r1, input logic [4:0] r2);
    drive(r, we, clr, wa, wd, r1, r2);
    #1;
    sample();
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rd1 cfg%0d addr%0d", k, r1), act1[k], expect_rd(k, r, we, clr, wa, wd, r1));
      chk($sformatf("rd2 cfg%0d addr%0d", k, r2), act2[k], expect_rd(k, r, we, clr, wa, wd, r2));
    end
    @(posedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!r || clr) begin
        for (int i = 0; i < 32; i++) mdl[k][i] = 32'h0;
      end else if (wr_ok(k, r, we, clr, wa)) begin
        mdl[k][wa] = wd & msk[k];
      end
    end
    @(negedge clk);
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    model_clear();
    repeat (2) @(negedge clk);

    // Reset state
    step(1'b0, 1'b1, 1'b0, 5'd3, 32'h1234, 5'd3, 5'd4);
    chk("reset rd1", act1[1], 32'h0);
    chk("reset rd2", act2[1], 32'h0);

    // Table-driven vectors on config A (zero reg, bypass), from an all-zero state
    tbl[0] = '{1, 0, 5'd3,  32'h0000_0011, 5'd3,  5'd0,  32'h0000_0011, 32'h0};
    tbl[1] = '{1, 0, 5'd0,  32'hFFFF_FFFF, 5'd0,  5'd3,  32'h0,         32'h0000_0011};
    tbl[2] = '{0, 0, 5'd0,  32'h0,         5'd3,  5'd3,  32'h0000_0011, 32'h0000_0011};
    tbl[3] = '{1, 1, 5'd3,  32'h0000_0022, 5'd3,  5'd5,  32'h0000_0011, 32'h0};
    tbl[4] = '{0, 0, 5'd0,  32'h0,         5'd3,  5'd0,  32'h0,         32'h0};
    tbl[5] = '{1, 0, 5'd31, 32'hCAFE_F00D, 5'd31, 5'd30, 32'hCAFE_F00D, 32'h0};
    tbl[6] = '{1, 0, 5'd30, 32'h0000_0001, 5'd31, 5'd30, 32'hCAFE_F00D, 32'h0000_0001};
    tbl[7] = '{0, 0, 5'd0,  32'h0,         5'd30, 5'd31, 32'h0000_0001, 32'hCAFE_F00D};
    for (int t = 0; t < 8; t++) begin
      step(1'b1, tbl[t].we, tbl[t].clr, tbl[t].wa, tbl[t].wd, tbl[t].r1, tbl[t].r2);
      chk($sformatf("tbl%0d rd1", t), act1[0], tbl[t].e1);
      chk($sformatf("tbl%0d rd2", t), act2[0], tbl[t].e2);
    end

    // Mid-cycle reset pulse of 3 ns between edges
    for (int i = 1; i <= 3; i++) step(1'b1, 1'b1, 1'b0, 5'(i), 32'hDEAD_BEEF, 5'(i), 5'd0);
    drive(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd1, 5'd2);
    #1 rst = 1'b0;
    #0.5;
    for (int a = 0; a < 32; a++) begin
      ifa.raddr1 = 5'(a); ifa.raddr2 = 5'(31 - a);
      ifb.raddr1 = 5'(a); ifb.raddr2 = 5'(31 - a);
      ifc.raddr1 = 5'(a); ifc.raddr2 = 5'(31 - a);
      #0.05;
      sample();
      for (int k = 0; k < 3; k++) begin
        chk($sformatf("in-reset rd1 cfg%0d addr%0d", k, a), act1[k], 32'h0);
        chk($sformatf("in-reset rd2 cfg%0d addr%0d", k, a), act2[k], 32'h0);
      end
    end
    #0.9 rst = 1'b1;
    model_clear();
    @(negedge clk);
    step(1'b1, 1'b1, 1'b0, 5'd5, 32'h1234_5678, 5'd1, 5'd2);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    chk("post-reset write A", act1[0], 32'h1234_5678);
    chk("post-reset write B", act2[1], 32'h1234_5678);

    // Reset held across an edge overrides the pending write
    step(1'b0, 1'b1, 1'b0, 5'd9, 32'h0000_0077, 5'd9, 5'd9);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9);
    chk("reset beats write", act1[1], 32'h0);

    // Write all, read all with differing addresses
    for (int i = 0; i < 32; i++)
      step(1'b1, 1'b1, 1'b0, 5'(i), (i == 0) ? 32'hFFFF_FFFF : 32'(i) * 32'h0101_0101, 5'(i), 5'd0);
    for (int i = 0; i < 32; i++) begin
      step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));
      chk($sformatf("all A rd1 addr%0d", i), act1[0], (i == 0) ? 32'h0 : 32'(i) * 32'h0101_0101);
      chk($sformatf("all B rd1 addr%0d", i), act1[1], (i == 0) ? 32'hFFFF_FFFF : 32'(i) * 32'h0101_0101);
      chk($sformatf("all A rd2 addr%0d", 31 - i), act2[0], (i == 31) ? 32'h0 : 32'(31 - i) * 32'h0101_0101);
    end

    // Bypass vs no bypass
    step(1'b1, 1'b1, 1'b0, 5'd7, 32'hAAAA_0000, 5'd0, 5'd0);
    step(1'b1, 1'b1, 1'b0, 5'd7, 32'h5555_FFFF, 5'd7, 5'd7);
    chk("bypass A rd1", act1[0], 32'h5555_FFFF);
    chk("bypass A rd2", act2[0], 32'h5555_FFFF);
    chk("no-bypass B rd1", act1[1], 32'hAAAA_0000);
    chk("no-bypass B rd2", act2[1], 32'hAAAA_0000);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7);
    chk("no-bypass B after edge", act1[1], 32'h5555_FFFF);

    // Clear beats write, no bypass during clear
    step(1'b1, 1'b1, 1'b0, 5'd4, 32'h0000_ABCD, 5'd0, 5'd0);
    step(1'b1, 1'b1, 1'b1, 5'd4, 32'h0000_0001, 5'd4, 5'd4);
    chk("clr no bypass A", act1[0], 32'h0000_ABCD);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd4, 5'd7);
    chk("clr entry4 A", act1[0], 32'h0);
    chk("clr entry7 B", act2[1], 32'h0);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i));

    // Non-power-of-two depth (config C, DEPTH=20, WIDTH=8)
    step(1'b1, 1'b1, 1'b0, 5'd25, 32'h0000_003C, 5'd25, 5'd19);
    chk("oor read C", act1[2], 32'h0);
    step(1'b1, 1'b1, 1'b0, 5'd19, 32'h0000_003C, 5'd19, 5'd25);
    chk("entry19 bypass C", act1[2], 32'h0000_003C);
    chk("oor read C p2", act2[2], 32'h0);
    step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd19, 5'd25);
    chk("entry19 stored C", act1[2], 32'h0000_003C);
    for (int i = 0; i < 32; i++) step(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(i));

    // Randomized run against the model
    for (int n = 0; n < 10000; n++) begin
      bit          r, we, clr;
      logic [4:0]  wa, r1, r2;
      logic [31:0] wd;
      r   = ($urandom_range(99) != 0);
      clr = ($urandom_range(19) == 0);
      we  = ($urandom_range(1) == 1);
      wa  = 5'($urandom_range(31));
      wd  = $urandom;
      r1  = ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31));
      r2  = ($urandom_range(3) == 0) ? wa : 5'($urandom_range(31));
      step(r, we, clr, wa, wd, r1, r2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
